cpu_bus_master: RTL
===================

Name: cpu_bus_master

Overview:
- Parametrised bus-interface unit between the 65832 core's execution logic and the external peripheral bus (o_bus_clk/o_bus_we/o_bus_addr/o_bus_data/i_bus_data/i_bus_data_ready).
- Accepts one load/store request of 1, 2 or 4 bytes and runs it as sequential byte beats on the 8-bit bus, honouring wait states.
- Returns assembled little-endian read data, or write completion, with an error flag.
- Supersedes the ad-hoc bus driving inside the core: width, address size and transfer size are generalised.

Parameters:
- ADDR_W, 32, bus/request address width in bits.
- DATA_W, 32, request data width in bits; legal values 8, 16, 32; max transfer = DATA_W/8 bytes.
- TIMEOUT, 255, wait cycles in STROBE before abort (used only with CPU_BUS_TIMEOUT_EN).

Ports:
- i_cpu_clk  in  1  clock; all logic on rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_req_valid  in  1  request present.
- o_req_ready  out  1  high only in IDLE; request accepted on edge where valid&ready.
- i_req_we  in  1  1=write, 0=read.
- i_req_addr  in  ADDR_W  address of byte 0.
- i_req_size  in  2  0=1 byte, 1=2 bytes, 2=4 bytes, 3=illegal.
- i_req_wdata  in  DATA_W  write data; byte k = bits [8k+7:8k].
- o_rsp_valid  out  1  one-cycle completion pulse.
- o_rsp_rdata  out  DATA_W  read data, valid with o_rsp_valid.
- o_rsp_err  out  1  error flag, valid with o_rsp_valid.
- o_bus_clk  out  1  bus strobe.
- o_bus_we  out  1  bus write enable.
- o_bus_addr  out  ADDR_W  bus byte address.
- o_bus_data  out  8  bus write byte.
- i_bus_data  in  8  bus read byte.
- i_bus_data_ready  in  1  slave completes current beat.

Behaviour:
- Reset: all outputs 0 except o_req_ready=1; state IDLE; beat counter 0. Reset is asynchronous, so assertion mid-transfer drops o_bus_clk immediately; the transfer is discarded and no response is issued.
- States: IDLE, SETUP, STROBE, RESP.
- IDLE -> SETUP on accept, if size legal and bytes<=DATA_W/8.
  - Latch we/addr/wdata; nbytes = 1<<size; beat=0; clear rdata.
- IDLE -> RESP on accept with illegal size or bytes>DATA_W/8.
  - o_rsp_err=1, rdata=0, no bus activity.
- SETUP (1 cycle): o_bus_clk=0.
  - o_bus_addr = latched addr + beat, modulo 2^ADDR_W (wraps from all-ones to 0).
  - o_bus_we = we; o_bus_data = wdata byte[beat] for writes, 0 for reads.
  - Next state STROBE.
- STROBE: o_bus_clk=1; addr/we/data held stable.
  - Each cycle sample i_bus_data_ready; while 0, remain in STROBE (wait state).
  - When 1 and read: capture i_bus_data into rdata byte[beat].
  - When 1: o_bus_clk=0 next cycle. If beat==nbytes-1 -> RESP, else beat+1 -> SETUP.
- RESP (1 cycle): o_rsp_valid=1 with rdata/err; o_bus_we=0; o_bus_clk=0; next IDLE.
  - o_rsp_rdata bytes >= nbytes are 0.
- Latency with zero wait states:
  - o_rsp_valid asserts 2*nbytes+1 cycles after the accept edge; 1 byte = 3 cycles.
  - Each wait cycle adds 1.
- Back-to-back: o_req_ready low in SETUP/STROBE/RESP. The next accept is possible in the IDLE cycle after RESP, giving a minimum period of 4 cycles for 1-byte transfers.
- i_req_valid while not ready is ignored; the core holds the request.
- i_bus_data_ready outside STROBE is ignored.
- o_rsp_rdata and o_rsp_err hold their last values after the pulse until the next RESP.

Optional Feature:
- CPU_BUS_TIMEOUT_EN defined:
  - An 8+ bit wait counter clears on entering STROBE and increments each cycle ready is 0.
  - When the counter reaches TIMEOUT: abort, o_bus_clk=0 next cycle, go to RESP with o_rsp_err=1; bytes already captured are kept, the rest are 0.
- Undefined: no counter; STROBE waits indefinitely; o_rsp_err is set only for an illegal size.

Test Plan:
- Read size 0 at addr 0x00009F00, slave ready immediately, i_bus_data=0x5A -> one beat; o_bus_clk high 1 cycle; o_rsp_valid 3 cycles after accept; rdata=0x0000005A; err=0.
- Write size 2 addr 0x00001000 wdata 0x11223344 -> 4 beats at addr 0x1000..0x1003 with data 0x44,0x33,0x22,0x11; o_bus_we=1 each beat; rsp 9 cycles after accept; err=0.
- Read size 1 addr 0xFFFFFFFF, ready delayed 3 cycles on beat 0 -> second beat addr 0x00000000 (wrap); rdata={0, byte1, byte0}; latency 5+3=8 cycles.
- Size 3, or size 2 with DATA_W=16 -> no o_bus_clk activity; rsp 1 cycle after accept; err=1; rdata=0.
- Assert i_rst during beat 1 of a 4-byte read -> o_bus_clk=0 immediately, no rsp_valid, o_req_ready=1 after release; a new 1-byte read completes normally.
- With CPU_BUS_TIMEOUT_EN and TIMEOUT=4, ready held 0 on beat 1 of a 2-byte read (byte0=0xAB) -> abort after 4 wait cycles; err=1; rdata=0x00AB.

Source files
------------

// File: rtl/cpu_bus_master.sv
// Byte-serial bus master: runs a 1/2/4-byte load or store as 8-bit beats with wait states.
// Optional STROBE wait timeout is compiled in with `define CPU_BUS_TIMEOUT_EN.
module cpu_bus_master #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              i_cpu_clk,
  input  logic              i_rst,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_we,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [1:0]        i_req_size,
  input  logic [DATA_W-1:0] i_req_wdata,
  output logic              o_rsp_valid,
  output logic [DATA_W-1:0] o_rsp_rdata,
  output logic              o_rsp_err,
  output logic              o_bus_clk,
  output logic              o_bus_we,
  output logic [ADDR_W-1:0] o_bus_addr,
  output logic [7:0]        o_bus_data,
  input  logic [7:0]        i_bus_data,
  input  logic              i_bus_data_ready
);

  localparam int NB = DATA_W / 8;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_STROBE = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  if (TIMEOUT < 1 || (DATA_W != 8 && DATA_W != 16 && DATA_W != 32)) begin : g_bad_param
    $error("cpu_bus_master: illegal DATA_W or TIMEOUT");
  end

  logic [1:0]        state_q, state_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [1:0]        last_q, last_d;
  logic [1:0]        beat_q, beat_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
`ifdef CPU_BUS_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
`endif

  logic              accept;
  logic              size_ok;
  logic              bus_act;
  logic [7:0]        wbyte;
  logic [DATA_W-1:0] rdata_cap;
  logic [DATA_W-1:0] rdata_nxt;

  assign accept  = i_req_valid && (state_q == S_IDLE);
  assign size_ok = (i_req_size != 2'd3) && ((32'd1 << i_req_size) <= 32'(NB));
  assign bus_act = (state_q == S_SETUP) || (state_q == S_STROBE);

  always_comb begin
    wbyte     = 8'h00;
    rdata_cap = rdata_q;
    for (int k = 0; k < NB; k++) begin
      if (beat_q == 2'(k)) begin
        wbyte                 = wdata_q[8*k +: 8];
        rdata_cap[8*k +: 8]   = i_bus_data;
      end
    end
    rdata_nxt = we_q ? rdata_q : rdata_cap;
  end

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    last_d      = last_q;
    beat_d      = beat_q;
    rdata_d     = rdata_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
`ifdef CPU_BUS_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (size_ok) begin
            we_d    = i_req_we;
            addr_d  = i_req_addr;
            wdata_d = i_req_wdata;
            // Index of the final beat: 0, 1 or 3 for 1, 2 or 4 bytes.
            last_d  = {i_req_size[1], i_req_size[1] | i_req_size[0]};
            beat_d  = 2'd0;
            rdata_d = '0;
            state_d = S_SETUP;
          end else begin
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
            state_d     = S_RESP;
          end
        end
      end
      S_SETUP: begin
`ifdef CPU_BUS_TIMEOUT_EN
        cnt_d   = '0;
`endif
        state_d = S_STROBE;
      end
      S_STROBE: begin
        if (i_bus_data_ready) begin
          rdata_d = rdata_nxt;
          if (beat_q == last_q) begin
            rsp_rdata_d = rdata_nxt;
            rsp_err_d   = 1'b0;
            state_d     = S_RESP;
          end else begin
            beat_d  = beat_q + 2'd1;
            state_d = S_SETUP;
          end
        end
`ifdef CPU_BUS_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          // This wait cycle brings the count to TIMEOUT: abort keeping captured bytes.
          rsp_rdata_d = rdata_q;
          rsp_err_d   = 1'b1;
          state_d     = S_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_cpu_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      last_q      <= 2'd0;
      beat_q      <= 2'd0;
      rdata_q     <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
`ifdef CPU_BUS_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      last_q      <= last_d;
      beat_q      <= beat_d;
      rdata_q     <= rdata_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
`ifdef CPU_BUS_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  // Bus outputs decode straight from state flops so reset drops them at once.
  assign o_req_ready = (state_q == S_IDLE);
  assign o_rsp_valid = (state_q == S_RESP);
  assign o_rsp_rdata = rsp_rdata_q;
  assign o_rsp_err   = rsp_err_q;
  assign o_bus_clk   = (state_q == S_STROBE);
  assign o_bus_we    = bus_act && we_q;
  assign o_bus_addr  = bus_act ? (addr_q + ADDR_W'(beat_q)) : '0;
  assign o_bus_data  = (bus_act && we_q) ? wbyte : 8'h00;

endmodule
